// File: rtl/mult_pkg.sv
// Shared types and widths for the sequential 6x6 shift-add multiplier.
package mult_pkg;

    localparam int unsigned OpW          = 6;
    localparam int unsigned AddW         = 11;
    localparam int unsigned ProdW        = 12;
    localparam int unsigned CntW         = 3;
    localparam int unsigned DefTruncCols = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/cla11.sv
// 11-bit carry-lookahead adder, carry-in tied low; every carry is a flattened
// generate/propagate sum-of-products rather than a ripple chain.
module cla11
    import mult_pkg::*;
(
    input  logic [AddW-1:0] a_i,
    input  logic [AddW-1:0] b_i,
    output logic [AddW-1:0] sum_o,
    output logic            cout_o
);

    logic [AddW-1:0] gen;
    logic [AddW-1:0] prop;
    logic [AddW:0]   carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    always_comb begin
        logic term;
        term  = 1'b0;
        carry = '0;
        for (int i = 1; i <= int'(AddW); i++) begin
            for (int k = 0; k < i; k++) begin
                term = gen[k];
                for (int j = k + 1; j < i; j++) begin
                    term = term & prop[j];
                end
                carry[i] = carry[i] | term;
            end
        end
    end

    assign sum_o  = prop ^ carry[AddW-1:0];
    assign cout_o = carry[AddW];

endmodule

// File: rtl/seq_mult6_ctrl.sv
// Sequential 6x6 unsigned shift-add multiplier sharing one CLA11 across its
// accumulate steps, with optional column truncation and early termination.
module seq_mult6_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned TRUNC_COLS = DefTruncCols,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OpW-1:0]   a,
    input  logic [OpW-1:0]   b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ProdW-1:0] product,
    output logic             busy
);

    state_e           state_q;
    logic [OpW-1:0]   a_q;
    logic [OpW-1:0]   b_q;
    logic             approx_q;
    logic [ProdW-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;
    logic [ProdW-1:0] product_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [OpW-1:0]   pp;
    logic [AddW-1:0]  addend;
    logic [AddW-1:0]  add_sum;
    logic             add_cout;
    logic [ProdW-1:0] acc_d;
    logic             last_step;

    // Keeps bit j of the partial product unless its column weight cnt+j is truncated.
    function automatic logic [OpW-1:0] trunc_mask(input logic [CntW-1:0] cnt,
                                                  input logic            approx);
        logic [OpW-1:0] m;
        m = '1;
        for (int j = 0; j < int'(OpW); j++) begin
            if (approx && ((int'(cnt) + j) < int'(TRUNC_COLS))) begin
                m[j] = 1'b0;
            end
        end
        return m;
    endfunction

    always_comb begin
        pp        = b_q[cnt_q] ? (a_q & trunc_mask(cnt_q, approx_q)) : '0;
        addend    = AddW'(pp) << cnt_q;
        acc_d     = {add_cout, add_sum};
        last_step = (cnt_q == CntW'(OpW - 1)) ||
                    (EARLY_TERM && ((b_q >> (cnt_q + CntW'(1))) == '0));
    end

    cla11 u_adder (
        .a_i    (acc_q[AddW-1:0]),
        .b_i    (addend),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            approx_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        approx_q   <= approx_en;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    if (last_step) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mult6_ctrl.sv
// Directed and randomized checks of seq_mult6_ctrl; index 0 is EARLY_TERM=0, index 1 is EARLY_TERM=1.
module tb_seq_mult6_ctrl;

    localparam int Trunc = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [2];
    logic [5:0]  a_s         [2];
    logic [5:0]  b_s         [2];
    logic        approx_s    [2];
    logic        out_ready_s [2];
    logic        in_ready_w  [2];
    logic        out_valid_w [2];
    logic [11:0] product_w   [2];
    logic        busy_w      [2];

    int checks;
    int failures;
    int perm [4096];

    seq_mult6_ctrl #(.TRUNC_COLS(Trunc), .EARLY_TERM(1'b0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_w[0]),
        .a         (a_s[0]),
        .b         (b_s[0]),
        .approx_en (approx_s[0]),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready_s[0]),
        .product   (product_w[0]),
        .busy      (busy_w[0])
    );

    seq_mult6_ctrl #(.TRUNC_COLS(Trunc), .EARLY_TERM(1'b1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_w[1]),
        .a         (a_s[1]),
        .b         (b_s[1]),
        .approx_en (approx_s[1]),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready_s[1]),
        .product   (product_w[1]),
        .busy      (busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Product from the partial-product matrix: drop cells in columns below Trunc when approx.
    function automatic int ref_prod(input int av, input int bv, input bit ap);
        int p;
        p = av * bv;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                if (ap && (i + j < Trunc) && ((bv >> i) & 1) == 1 && ((av >> j) & 1) == 1)
                    p -= (1 << (i + j));
        return p;
    endfunction

    function automatic int ref_lat(input int d, input int bv);
        int m;
        if (d == 0) return 6;
        if (bv == 0) return 1;
        m = 0;
        for (int i = 0; i < 6; i++) if (((bv >> i) & 1) == 1) m = i;
        return m + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int d, input int av, input int bv, input bit ap);
        int n;
        n = 0;
        while (in_ready_w[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 0, 1);
        in_valid_s[d] = 1'b1;
        a_s[d]        = 6'(av);
        b_s[d]        = 6'(bv);
        approx_s[d]   = ap;
        tick();
        in_valid_s[d] = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_done(input int d, input bit chk_ready, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (chk_ready && in_ready_w[d] !== 1'b0) chk("in_ready_in_calc", in_ready_w[d], 0);
            if (out_valid_w[d] === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic handshake(input int d);
        out_ready_s[d] = 1'b1;
        tick();
        out_ready_s[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input int av, input int bv, input bit ap,
                          input string tag, input bit verbose);
        int cyc;
        start_op(d, av, bv, ap);
        wait_done(d, verbose, cyc);
        chk({tag, "_lat"}, cyc, ref_lat(d, bv));
        chk({tag, "_prod"}, product_w[d], ref_prod(av, bv, ap));
        handshake(d);
        if (verbose) begin
            chk({tag, "_ov_drop"}, out_valid_w[d], 0);
            chk({tag, "_ready_back"}, in_ready_w[d], 1);
        end
    endtask

    initial begin
        int cyc;
        int tmp;
        int r;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_s[d]  = 1'b0;
            a_s[d]         = '0;
            b_s[d]         = '0;
            approx_s[d]    = 1'b0;
            out_ready_s[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", in_ready_w[d], 0);
            chk("rst_out_valid", out_valid_w[d], 0);
            chk("rst_product", product_w[d], 0);
            chk("rst_busy", busy_w[d], 0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready_w[0], 1);
        chk("post_rst_busy", busy_w[0], 0);

        run_op(0, 63, 63, 1'b0, "full_exact", 1'b1);
        run_op(0, 63, 63, 1'b1, "full_approx", 1'b1);
        run_op(1, 5, 1, 1'b0, "et_b1", 1'b1);
        run_op(1, 9, 0, 1'b0, "et_b0", 1'b1);

        // Backpressure: hold out_ready low while a second request waits.
        start_op(1, 7, 8, 1'b0);
        wait_done(1, 1'b1, cyc);
        chk("bp_lat", cyc, 4);
        in_valid_s[1] = 1'b1;
        a_s[1]        = 6'd2;
        b_s[1]        = 6'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_ov_held", out_valid_w[1], 1);
            chk("bp_prod_held", product_w[1], 56);
            chk("bp_not_accepted", in_ready_w[1], 0);
        end
        handshake(1);
        chk("bp_idle_ready", in_ready_w[1], 1);
        tick();
        in_valid_s[1] = 1'b0;
        chk("bp_accept_busy", busy_w[1], 1);
        wait_done(1, 1'b1, cyc);
        chk("bp2_lat", cyc, 2);
        chk("bp2_prod", product_w[1], 6);
        handshake(1);

        // approx_en toggling mid-operation must not matter.
        start_op(0, 45, 27, 1'b0);
        approx_s[0] = 1'b1;
        wait_done(0, 1'b1, cyc);
        chk("apx_change_prod", product_w[0], 45 * 27);
        handshake(0);

        // Reset pulse mid-CALC.
        start_op(0, 63, 63, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_ov", out_valid_w[0], 0);
        chk("midrst_busy", busy_w[0], 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready", in_ready_w[0], 1);
        chk("midrst_ov2", out_valid_w[0], 0);
        run_op(0, 10, 12, 1'b0, "after_rst", 1'b1);

        for (int k = 0; k < 8; k++)
            run_op(k % 2, $urandom_range(63, 0), $urandom_range(63, 0), 1'b1, "rand_approx", 1'b0);

        // Every (a,b) pair in shuffled order on both variants.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4096; i++) perm[i] = i;
            for (int i = 4095; i > 0; i--) begin
                r       = int'($urandom_range(i, 0));
                tmp     = perm[i];
                perm[i] = perm[r];
                perm[r] = tmp;
            end
            for (int i = 0; i < 4096; i++)
                run_op(d, perm[i] >> 6, perm[i] & 63, 1'b0, d == 0 ? "sweep_et0" : "sweep_et1",
                       1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
